// File: rtl/rv32imf_prefetch_ctrl_mo_if.sv
// Bundle of fetch-side, bus-side and FIFO-side signals around the prefetch
// controller. Suffixes (_i/_o) are relative to the controller (master).
interface rv32imf_prefetch_ctrl_mo_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             req_i;
  logic             branch_i;
  logic [31:0]      branch_addr_i;
  logic             busy_o;
  logic             trans_valid_o;
  logic             trans_ready_i;
  logic [31:0]      trans_addr_o;
  logic             resp_valid_i;
  logic             fetch_ready_i;
  logic             fetch_valid_o;
  logic             fifo_push_o;
  logic             fifo_pop_o;
  logic             fifo_flush_o;
  logic [CNT_W-1:0] fifo_cnt_i;
  logic             fifo_empty_i;
  logic [CNT_W-1:0] outstanding_o;

  modport master (
    input  req_i, branch_i, branch_addr_i, trans_ready_i, resp_valid_i,
           fetch_ready_i, fifo_cnt_i, fifo_empty_i,
    output busy_o, trans_valid_o, trans_addr_o, fetch_valid_o,
           fifo_push_o, fifo_pop_o, fifo_flush_o, outstanding_o
  );

  modport slave (
    output req_i, branch_i, branch_addr_i, trans_ready_i, resp_valid_i,
           fetch_ready_i, fifo_cnt_i, fifo_empty_i,
    input  busy_o, trans_valid_o, trans_addr_o, fetch_valid_o,
           fifo_push_o, fifo_pop_o, fifo_flush_o, outstanding_o
  );
endinterface

// File: rtl/rv32imf_prefetch_ctrl_mo.sv
// Instruction prefetch controller: issues word-aligned sequential fetches,
// redirects on taken branches, drops responses belonging to stale fetches,
// limits outstanding transactions and optionally holds sequential fetches
// at page boundaries until all earlier work has drained.
//
// state       | meaning
// ------------+----------------------------------------------------------
// IDLE        | sequential fetching, next address = last address + 4
// BRANCH_WAIT | redirect taken but not yet accepted, address = held target
// PAGE_HOLD   | last word of a page issued; next sequential fetch waits
//             | until nothing is outstanding and the FIFO is empty
module rv32imf_prefetch_ctrl_mo #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          PAGE_BITS       = 12,
  parameter logic [31:0] RESET_ADDR      = 32'h0000_0000,
  parameter int          CNT_W           = $clog2(DEPTH + 1)
) (
  input logic clk,
  input logic rst,
  rv32imf_prefetch_ctrl_mo_if.master bus
);

  typedef enum logic [1:0] {IDLE, BRANCH_WAIT, PAGE_HOLD} state_t;

  localparam int               CW1     = CNT_W + 1;
  localparam logic [CW1-1:0]   DEPTH_C = CW1'(DEPTH);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_OUTSTANDING);
  // Word-index bits inside a page; all ones marks the last word.
  localparam logic [31:0] PAGE_MASK = (PAGE_BITS == 0) ? 32'h0 :
    (((32'h1 << PAGE_BITS) - 32'h1) & 32'hFFFF_FFFC);

  state_t           state_q, state_d;
  logic [31:0]      trans_addr_q, trans_addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [31:0]      tgt, incr, addr_o;
  logic [CNT_W-1:0] fcm;
  logic             space, hold_block, trans_valid, acc, kill, last_word;
  logic             unused_bits;

  assign unused_bits = ^{bus.branch_addr_i[1:0], trans_addr_q[1:0]};

  // Request qualification and address selection.
  always_comb begin
    tgt         = {bus.branch_addr_i[31:2], 2'b00};
    incr        = {trans_addr_q[31:2], 2'b00} + 32'd4;
    // A branch flushes the FIFO, so its occupancy no longer limits space.
    fcm         = bus.branch_i ? '0 : bus.fifo_cnt_i;
    space       = ({1'b0, fcm} + {1'b0, cnt_q}) < DEPTH_C;
    hold_block  = (state_q == PAGE_HOLD) && !bus.branch_i &&
                  ((cnt_q != '0) || !bus.fifo_empty_i);
    trans_valid = bus.req_i && space && (cnt_q < MAX_C) && !hold_block;
    acc         = trans_valid && bus.trans_ready_i;
    if (bus.branch_i)
      addr_o = tgt;
    else if (state_q == BRANCH_WAIT)
      addr_o = trans_addr_q;
    else
      addr_o = incr;
    last_word   = (PAGE_BITS != 0) && ((addr_o & PAGE_MASK) == PAGE_MASK);
    kill        = bus.branch_i || (flush_cnt_q != '0);
  end

  // Next-state, address, outstanding and flush counter updates.
  always_comb begin
    state_d = state_q;
    if (acc)
      state_d = last_word ? PAGE_HOLD : IDLE;
    else if (bus.branch_i)
      state_d = BRANCH_WAIT;

    trans_addr_d = (bus.branch_i || acc) ? addr_o : trans_addr_q;

    cnt_d = cnt_q;
    if (acc && !bus.resp_valid_i)
      cnt_d = cnt_q + 1'b1;
    else if (!acc && bus.resp_valid_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;

    // Everything outstanding at a branch is stale; a response arriving in
    // the branch cycle itself is already dropped and not counted again.
    flush_cnt_d = flush_cnt_q;
    if (bus.branch_i)
      flush_cnt_d = cnt_q - CNT_W'(bus.resp_valid_i && (cnt_q != '0));
    else if (bus.resp_valid_i && (flush_cnt_q != '0))
      flush_cnt_d = flush_cnt_q - 1'b1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      trans_addr_q <= RESET_ADDR;
      cnt_q        <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      trans_addr_q <= trans_addr_d;
      cnt_q        <= cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bus.trans_valid_o = trans_valid;
  assign bus.trans_addr_o  = addr_o;
  assign bus.busy_o        = (cnt_q != '0) || trans_valid;
  assign bus.outstanding_o = cnt_q;
  assign bus.fetch_valid_o = (!bus.fifo_empty_i || bus.resp_valid_i) && !kill;
  // Bypass the FIFO when it is empty and IF can take the word directly.
  assign bus.fifo_push_o   = bus.resp_valid_i &&
                             (!bus.fifo_empty_i || !bus.fetch_ready_i) && !kill;
  assign bus.fifo_pop_o    = !bus.fifo_empty_i && bus.fetch_ready_i;
  assign bus.fifo_flush_o  = bus.branch_i;

endmodule

// File: tb/tb_rv32imf_prefetch_ctrl_mo.sv
// Self-checking bench for rv32imf_prefetch_ctrl_mo. Expected fetch addresses
// and expected deliver/drop decisions are queued as stimulus is driven and
// compared by a monitor when the DUT accepts a request or sees a response.
module tb_rv32imf_prefetch_ctrl_mo;
  localparam logic [31:0] RST_A = 32'h0000_0040;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] exp_addr_q[$];
  logic        exp_del_q[$];
  logic [31:0] mon_a;
  logic        mon_d;

  rv32imf_prefetch_ctrl_mo_if #(.DEPTH(4)) bus();

  rv32imf_prefetch_ctrl_mo #(
    .DEPTH(4), .MAX_OUTSTANDING(2), .PAGE_BITS(12), .RESET_ADDR(RST_A)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && bus.trans_valid_o && bus.trans_ready_i) begin
      total++;
      if (exp_addr_q.size() == 0) begin
        bad++; $display("FAIL accept_addr: got %h, none expected", bus.trans_addr_o);
      end else begin
        mon_a = exp_addr_q.pop_front();
        if (bus.trans_addr_o !== mon_a) begin
          bad++; $display("FAIL accept_addr: got %h want %h", bus.trans_addr_o, mon_a);
        end
      end
    end
    if (!rst && bus.resp_valid_i) begin
      total++;
      if (exp_del_q.size() == 0) begin
        bad++; $display("FAIL resp_deliver: response with no expectation");
      end else begin
        mon_d = exp_del_q.pop_front();
        if ((bus.fetch_valid_o || bus.fifo_push_o) !== mon_d) begin
          bad++; $display("FAIL resp_deliver: got %b want %b", bus.fetch_valid_o || bus.fifo_push_o, mon_d);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    bus.resp_valid_i = 1'b0;
    bus.branch_i     = 1'b0;
  endtask

  task automatic give_resp(input logic deliver);
    bus.resp_valid_i = 1'b1;
    exp_del_q.push_back(deliver);
  endtask

  task automatic branch_to(input logic [31:0] a);
    bus.branch_i      = 1'b1;
    bus.branch_addr_i = a;
  endtask

  task automatic test_reset();
    #1;
    total++; if (bus.trans_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.trans_valid_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy_o); end
    total++; if (bus.outstanding_o !== 3'd0) begin bad++; $display("FAIL rst_outst got=%0d want=0", bus.outstanding_o); end
    total++; if ({bus.fetch_valid_o, bus.fifo_push_o, bus.fifo_pop_o, bus.fifo_flush_o} !== 4'b0) begin
      bad++; $display("FAIL rst_ctrl got=%b want=0000", {bus.fetch_valid_o, bus.fifo_push_o, bus.fifo_pop_o, bus.fifo_flush_o});
    end
    bus.req_i = 1'b1; #1;
    total++; if (bus.trans_valid_o !== 1'b1) begin bad++; $display("FAIL rst_req_valid got=%b want=1", bus.trans_valid_o); end
    total++; if (bus.trans_addr_o !== RST_A + 32'd4) begin bad++; $display("FAIL rst_req_addr got=%h want=%h", bus.trans_addr_o, RST_A + 32'd4); end
    bus.req_i = 1'b0;
    step();
  endtask

  task automatic test_sequential();
    bus.req_i = 1'b1; bus.trans_ready_i = 1'b1; branch_to(32'h101);
    exp_addr_q.push_back(32'h100); #1;
    total++; if (bus.trans_addr_o !== 32'h100) begin bad++; $display("FAIL seq_br_addr got=%h want=100", bus.trans_addr_o); end
    total++; if (bus.fifo_flush_o !== 1'b1) begin bad++; $display("FAIL seq_flush got=%b want=1", bus.fifo_flush_o); end
    step();
    exp_addr_q.push_back(32'h104); #1;
    total++; if (bus.trans_addr_o !== 32'h104) begin bad++; $display("FAIL seq_addr2 got=%h want=104", bus.trans_addr_o); end
    step();
    give_resp(1'b1); #1;
    total++; if (bus.trans_valid_o !== 1'b0) begin bad++; $display("FAIL seq_max_valid got=%b want=0", bus.trans_valid_o); end
    total++; if (bus.outstanding_o !== 3'd2) begin bad++; $display("FAIL seq_max_cnt got=%0d want=2", bus.outstanding_o); end
    step();
    exp_addr_q.push_back(32'h108); #1;
    total++; if (bus.trans_addr_o !== 32'h108) begin bad++; $display("FAIL seq_addr3 got=%h want=108", bus.trans_addr_o); end
    step();
    bus.req_i = 1'b0; give_resp(1'b1); step();
    give_resp(1'b1); step();
    #1;
    total++; if (bus.outstanding_o !== 3'd0) begin bad++; $display("FAIL seq_drain_cnt got=%0d want=0", bus.outstanding_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL seq_drain_busy got=%b want=0", bus.busy_o); end
  endtask

  task automatic test_space();
    bus.req_i = 1'b1; exp_addr_q.push_back(32'h10C); step();
    bus.trans_ready_i = 1'b0; bus.fifo_cnt_i = 3'd3; bus.fifo_empty_i = 1'b0; #1;
    total++; if (bus.trans_valid_o !== 1'b0) begin bad++; $display("FAIL space_full got=%b want=0", bus.trans_valid_o); end
    branch_to(32'h180); #1;
    total++; if (bus.trans_valid_o !== 1'b1) begin bad++; $display("FAIL space_branch got=%b want=1", bus.trans_valid_o); end
    total++; if (bus.trans_addr_o !== 32'h180) begin bad++; $display("FAIL space_br_addr got=%h want=180", bus.trans_addr_o); end
    step();
    bus.fifo_cnt_i = 3'd0; bus.fifo_empty_i = 1'b1; give_resp(1'b0); #1;
    total++; if (bus.trans_addr_o !== 32'h180) begin bad++; $display("FAIL space_bw_addr got=%h want=180", bus.trans_addr_o); end
    total++; if (bus.fifo_push_o !== 1'b0) begin bad++; $display("FAIL space_stale_push got=%b want=0", bus.fifo_push_o); end
    step();
    bus.trans_ready_i = 1'b1; exp_addr_q.push_back(32'h180); step();
    bus.req_i = 1'b0; give_resp(1'b1); step();
  endtask

  task automatic test_branch_flush();
    bus.req_i = 1'b1; exp_addr_q.push_back(32'h184); step();
    exp_addr_q.push_back(32'h188); step();
    bus.trans_ready_i = 1'b0; branch_to(32'h200); #1;
    total++; if (bus.trans_addr_o !== 32'h200) begin bad++; $display("FAIL bf_addr got=%h want=200", bus.trans_addr_o); end
    total++; if (bus.trans_valid_o !== 1'b0) begin bad++; $display("FAIL bf_valid_full got=%b want=0", bus.trans_valid_o); end
    step();
    give_resp(1'b0); #1;
    total++; if (bus.trans_addr_o !== 32'h200) begin bad++; $display("FAIL bf_hold_addr got=%h want=200", bus.trans_addr_o); end
    total++; if (bus.fetch_valid_o !== 1'b0) begin bad++; $display("FAIL bf_kill1 got=%b want=0", bus.fetch_valid_o); end
    step();
    give_resp(1'b0); #1;
    total++; if (bus.trans_valid_o !== 1'b1) begin bad++; $display("FAIL bf_valid got=%b want=1", bus.trans_valid_o); end
    step();
    bus.trans_ready_i = 1'b1; exp_addr_q.push_back(32'h200); step();
    bus.req_i = 1'b0; give_resp(1'b1); #1;
    total++; if (bus.fetch_valid_o !== 1'b1) begin bad++; $display("FAIL bf_deliver got=%b want=1", bus.fetch_valid_o); end
    step();
  endtask

  task automatic test_branch_override();
    bus.req_i = 1'b1; bus.trans_ready_i = 1'b0; branch_to(32'h300); step();
    branch_to(32'h340); #1;
    total++; if (bus.trans_addr_o !== 32'h340) begin bad++; $display("FAIL ovr_addr got=%h want=340", bus.trans_addr_o); end
    step();
    #1;
    total++; if (bus.trans_addr_o !== 32'h340) begin bad++; $display("FAIL ovr_hold got=%h want=340", bus.trans_addr_o); end
    bus.trans_ready_i = 1'b1; exp_addr_q.push_back(32'h340); step();
    bus.req_i = 1'b0; give_resp(1'b1); step();
  endtask

  task automatic test_page_guard();
    bus.req_i = 1'b1; branch_to(32'hFF8); exp_addr_q.push_back(32'hFF8); step();
    exp_addr_q.push_back(32'hFFC); #1;
    total++; if (bus.trans_addr_o !== 32'hFFC) begin bad++; $display("FAIL pg_last got=%h want=ffc", bus.trans_addr_o); end
    step();
    give_resp(1'b1); #1;
    total++; if (bus.trans_valid_o !== 1'b0) begin bad++; $display("FAIL pg_hold1 got=%b want=0", bus.trans_valid_o); end
    step();
    bus.fifo_cnt_i = 3'd1; bus.fifo_empty_i = 1'b0; #1;
    total++; if (bus.trans_valid_o !== 1'b0) begin bad++; $display("FAIL pg_hold_cnt got=%b want=0", bus.trans_valid_o); end
    step();
    give_resp(1'b1); step();
    #1;
    total++; if (bus.trans_valid_o !== 1'b0) begin bad++; $display("FAIL pg_hold_fifo got=%b want=0", bus.trans_valid_o); end
    step();
    bus.fifo_cnt_i = 3'd0; bus.fifo_empty_i = 1'b1; exp_addr_q.push_back(32'h1000); #1;
    total++; if (bus.trans_valid_o !== 1'b1) begin bad++; $display("FAIL pg_release got=%b want=1", bus.trans_valid_o); end
    step();
    exp_addr_q.push_back(32'h1004); #1;
    total++; if (bus.trans_valid_o !== 1'b1) begin bad++; $display("FAIL pg_idle_valid got=%b want=1", bus.trans_valid_o); end
    step();
    bus.req_i = 1'b0; give_resp(1'b1); step();
    give_resp(1'b1); step();
  endtask

  task automatic test_page_branch();
    bus.req_i = 1'b1; branch_to(32'h1FFC); exp_addr_q.push_back(32'h1FFC); step();
    bus.trans_ready_i = 1'b0; #1;
    total++; if (bus.trans_valid_o !== 1'b0) begin bad++; $display("FAIL pb_hold got=%b want=0", bus.trans_valid_o); end
    branch_to(32'h3000); bus.trans_ready_i = 1'b1; exp_addr_q.push_back(32'h3000); #1;
    total++; if (bus.trans_valid_o !== 1'b1) begin bad++; $display("FAIL pb_valid got=%b want=1", bus.trans_valid_o); end
    step();
    bus.req_i = 1'b0; give_resp(1'b0); step();
    give_resp(1'b1); step();
  endtask

  task automatic test_resp_with_branch();
    bus.req_i = 1'b1; exp_addr_q.push_back(32'h3004); step();
    exp_addr_q.push_back(32'h3008); step();
    bus.req_i = 1'b0; bus.trans_ready_i = 1'b0; branch_to(32'h400); give_resp(1'b0); #1;
    total++; if (bus.fifo_push_o !== 1'b0) begin bad++; $display("FAIL rb_push got=%b want=0", bus.fifo_push_o); end
    total++; if (bus.fifo_flush_o !== 1'b1) begin bad++; $display("FAIL rb_flush got=%b want=1", bus.fifo_flush_o); end
    step();
    give_resp(1'b0); step();
    #1;
    total++; if (bus.outstanding_o !== 3'd0) begin bad++; $display("FAIL rb_cnt got=%0d want=0", bus.outstanding_o); end
    bus.req_i = 1'b1; bus.trans_ready_i = 1'b1; exp_addr_q.push_back(32'h400); step();
    bus.req_i = 1'b0; give_resp(1'b1); step();
  endtask

  task automatic test_wrap();
    bus.req_i = 1'b1; branch_to(32'hFFFF_FFFC); exp_addr_q.push_back(32'hFFFF_FFFC); step();
    bus.req_i = 1'b0; give_resp(1'b1); step();
    bus.req_i = 1'b1; exp_addr_q.push_back(32'h0); #1;
    total++; if (bus.trans_addr_o !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h want=0", bus.trans_addr_o); end
    step();
    bus.req_i = 1'b0; give_resp(1'b1); step();
  endtask

  task automatic test_midreset();
    bus.req_i = 1'b1; exp_addr_q.push_back(32'h4); step();
    bus.req_i = 1'b0; rst = 1'b1; step();
    rst = 1'b0; #1;
    total++; if (bus.outstanding_o !== 3'd0) begin bad++; $display("FAIL mr_cnt got=%0d want=0", bus.outstanding_o); end
    bus.req_i = 1'b1; bus.trans_ready_i = 1'b0; #1;
    total++; if (bus.trans_addr_o !== RST_A + 32'd4) begin bad++; $display("FAIL mr_addr got=%h want=%h", bus.trans_addr_o, RST_A + 32'd4); end
    bus.req_i = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    bus.req_i = 1'b0; bus.branch_i = 1'b0; bus.branch_addr_i = 32'h0;
    bus.trans_ready_i = 1'b0; bus.resp_valid_i = 1'b0; bus.fetch_ready_i = 1'b1;
    bus.fifo_cnt_i = 3'd0; bus.fifo_empty_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_sequential();
    test_space();
    test_branch_flush();
    test_branch_override();
    test_page_guard();
    test_page_branch();
    test_resp_with_branch();
    test_wrap();
    test_midreset();
    total++; if (exp_addr_q.size() != 0) begin bad++; $display("FAIL sb_addr_left got=%0d want=0", exp_addr_q.size()); end
    total++; if (exp_del_q.size() != 0) begin bad++; $display("FAIL sb_resp_left got=%0d want=0", exp_del_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
